light_monitor: RTL and testbench

- Receiving end of the light-output bus: samples the farm and highway lamp vectors driven by the traffic controller.
- Checks them for illegal encodings, green/yellow conflicts, illegal colour transitions and yellow dwell violations.
- Latches the first fault with a code and asserts a fail-safe request for the top level to force all-red.
- Sits beside the controller in top, watching FARMTR/HIGHWAYTR.

---
 rtl/light_pkg.sv | 39 +++
 rtl/lamp_checker.sv | 59 +++++
 rtl/light_monitor.sv | 161 ++++++++++++++++
 tb/tb_light_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared lamp encodings, fault codes and transition rules for the light-output bus monitor.
package light_pkg;

  localparam int unsigned LAMP_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

  localparam logic ROAD_HWY  = 1'b0;
  localparam logic ROAD_FARM = 1'b1;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_ENC       = 3'd1,
    FC_CONFLICT  = 3'd2,
    FC_BAD_TRANS = 3'd3,
    FC_YEL_SHORT = 3'd4,
    FC_YEL_LONG  = 3'd5
  } fault_code_e;

  typedef struct packed {
    fault_code_e code;
    logic        road;
  } fault_t;

  function automatic logic is_one_hot(input logic [LAMP_W-1:0] v);
    return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
  endfunction

  // Only the normal colour sequence G->Y->R->G is a legal change.
  function automatic logic trans_legal(input logic [LAMP_W-1:0] from_v,
                                       input logic [LAMP_W-1:0] to_v);
    return ((from_v == LAMP_G) && (to_v == LAMP_Y)) ||
           ((from_v == LAMP_Y) && (to_v == LAMP_R)) ||
           ((from_v == LAMP_R) && (to_v == LAMP_G));
  endfunction

endpackage

// File: rtl/lamp_checker.sv
// Per-road lamp checker: tracks previous colour and yellow dwell, flags encoding,
// transition and dwell violations combinationally for the sample being taken this edge.
module lamp_checker
  import light_pkg::*;
#(
  parameter int unsigned YEL_MIN = 3,
  parameter int unsigned YEL_MAX = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LAMP_W-1:0] lamp_i,
  output logic              enc_c,
  output logic              bad_trans_c,
  output logic              yel_short_c,
  output logic              yel_long_c,
  output logic              valid_c,
  output logic              red_c
);

  logic [LAMP_W-1:0] prev_q;
  logic              prev_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    valid_c     = is_one_hot(lamp_i);
    red_c       = (lamp_i == LAMP_R);
    enc_c       = !valid_c;
    bad_trans_c = 1'b0;
    yel_short_c = 1'b0;
    yel_long_c  = 1'b0;
    cnt_d       = '0;

    // Dwell count includes the current yellow sample and saturates at all-ones.
    if (lamp_i == LAMP_Y) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    bad_trans_c = prev_valid_q && valid_c && (lamp_i != prev_q) &&
                  !trans_legal(prev_q, lamp_i);
    yel_short_c = (prev_q == LAMP_Y) && (lamp_i == LAMP_R) &&
                  (cnt_q < CNT_W'(YEL_MIN));
    yel_long_c  = (lamp_i == LAMP_Y) && (cnt_d >= CNT_W'(YEL_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= LAMP_R;
      prev_valid_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      prev_q       <= lamp_i;
      prev_valid_q <= valid_c;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Light-output bus monitor: latches the first lamp fault and requests fail-safe all-red.
// Optional flashing-red drive on FLASH is built when LIGHT_MONITOR_FLASH_EN is defined.
module light_monitor
  import light_pkg::*;
#(
  parameter int unsigned YEL_MIN = 3,
  parameter int unsigned YEL_MAX = 10,
  parameter int unsigned CNT_W   = 4
`ifdef LIGHT_MONITOR_FLASH_EN
  ,
  parameter int unsigned FLASH_HALF = 8
`endif
) (
  input  logic              Clk,
  input  logic              RS,
  input  logic [LAMP_W-1:0] FARMTR,
  input  logic [LAMP_W-1:0] HIGHWAYTR,
  input  logic              CLR,
  output logic              FAULT,
  output logic [2:0]        FAULT_CODE,
  output logic              FAULT_ROAD,
  output logic              FAILSAFE,
  output logic              FLASH
);

  logic h_enc, h_bad, h_short, h_long, h_valid, h_red;
  logic f_enc, f_bad, f_short, f_long, f_valid, f_red;

  lamp_checker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)) u_hwy (
    .clk        (Clk),
    .rst_n      (RS),
    .lamp_i     (HIGHWAYTR),
    .enc_c      (h_enc),
    .bad_trans_c(h_bad),
    .yel_short_c(h_short),
    .yel_long_c (h_long),
    .valid_c    (h_valid),
    .red_c      (h_red)
  );

  lamp_checker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .CNT_W(CNT_W)) u_farm (
    .clk        (Clk),
    .rst_n      (RS),
    .lamp_i     (FARMTR),
    .enc_c      (f_enc),
    .bad_trans_c(f_bad),
    .yel_short_c(f_short),
    .yel_long_c (f_long),
    .valid_c    (f_valid),
    .red_c      (f_red)
  );

  logic   conflict_c;
  logic   viol_c;
  fault_t new_c;
  fault_t fault_q, fault_d;
  logic   active_q, active_d;

  // Lowest fault code wins; within a code the highway road wins.
  always_comb begin
    conflict_c    = h_valid && f_valid && !h_red && !f_red;
    viol_c        = 1'b1;
    new_c.code    = FC_NONE;
    new_c.road    = ROAD_HWY;
    if (h_enc) begin
      new_c.code = FC_ENC;
    end else if (f_enc) begin
      new_c.code = FC_ENC;
      new_c.road = ROAD_FARM;
    end else if (conflict_c) begin
      new_c.code = FC_CONFLICT;
    end else if (h_bad) begin
      new_c.code = FC_BAD_TRANS;
    end else if (f_bad) begin
      new_c.code = FC_BAD_TRANS;
      new_c.road = ROAD_FARM;
    end else if (h_short) begin
      new_c.code = FC_YEL_SHORT;
    end else if (f_short) begin
      new_c.code = FC_YEL_SHORT;
      new_c.road = ROAD_FARM;
    end else if (h_long) begin
      new_c.code = FC_YEL_LONG;
    end else if (f_long) begin
      new_c.code = FC_YEL_LONG;
      new_c.road = ROAD_FARM;
    end else begin
      viol_c = 1'b0;
    end
  end

  // Sticky first-fault latch; a violation coinciding with CLR replaces the old fault.
  always_comb begin
    fault_d  = fault_q;
    active_d = active_q;
    if (viol_c && (!active_q || CLR)) begin
      fault_d  = new_c;
      active_d = 1'b1;
    end else if (CLR) begin
      fault_d.code = FC_NONE;
      fault_d.road = ROAD_HWY;
      active_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge RS) begin
    if (!RS) begin
      fault_q.code <= FC_NONE;
      fault_q.road <= ROAD_HWY;
      active_q     <= 1'b0;
    end else begin
      fault_q  <= fault_d;
      active_q <= active_d;
    end
  end

  assign FAULT      = active_q;
  assign FAILSAFE   = active_q;
  assign FAULT_CODE = fault_q.code;
  assign FAULT_ROAD = fault_q.road;

`ifdef LIGHT_MONITOR_FLASH_EN
  localparam int unsigned FW = $clog2(FLASH_HALF) + 1;

  logic          flash_q, flash_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;

  // Starts high when a fault is (re)latched, toggles every FLASH_HALF cycles.
  always_comb begin
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    if (!active_d) begin
      flash_d     = 1'b0;
      flash_cnt_d = '0;
    end else if (!active_q || CLR) begin
      flash_d     = 1'b1;
      flash_cnt_d = '0;
    end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
      flash_d     = !flash_q;
      flash_cnt_d = '0;
    end else begin
      flash_cnt_d = flash_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge Clk or negedge RS) begin
    if (!RS) begin
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign FLASH = flash_q;
`else
  assign FLASH = 1'b0;
`endif

endmodule

// File: tb/tb_light_monitor.sv
// Directed self-checking bench for light_monitor (default YEL_MIN=3, YEL_MAX=10, FLASH_HALF=8).
module tb_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       Clk;
  logic       RS;
  logic [2:0] FARMTR;
  logic [2:0] HIGHWAYTR;
  logic       CLR;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic       FAULT_ROAD;
  logic       FAILSAFE;
  logic       FLASH;

  int checks = 0;
  int passed = 0;

  light_monitor dut (
    .Clk       (Clk),
    .RS        (RS),
    .FARMTR    (FARMTR),
    .HIGHWAYTR (HIGHWAYTR),
    .CLR       (CLR),
    .FAULT     (FAULT),
    .FAULT_CODE(FAULT_CODE),
    .FAULT_ROAD(FAULT_ROAD),
    .FAILSAFE  (FAILSAFE),
    .FLASH     (FLASH)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Present one sample; it is taken on the next rising edge, outputs read 1 time unit later.
  task automatic drive(input logic [2:0] h, input logic [2:0] f, input logic c);
    HIGHWAYTR = h;
    FARMTR    = f;
    CLR       = c;
    @(posedge Clk);
    #1;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    RS = 1'b0; CLR = 1'b0; HIGHWAYTR = R; FARMTR = R;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (FAULT !== 1'b0) $display("FAIL reset_fault got %b want 0", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd0) $display("FAIL reset_code got %0d want 0", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL reset_road got %b want 0", FAULT_ROAD); else passed++;
    checks++; if (FAILSAFE !== 1'b0) $display("FAIL reset_failsafe got %b want 0", FAILSAFE); else passed++;
    checks++; if (FLASH !== 1'b0) $display("FAIL reset_flash got %b want 0", FLASH); else passed++;
    RS = 1'b1;
  endtask

  task automatic test_legal_cycle();
    logic [2:0] sh[$];
    logic [2:0] sf[$];
    sh.push_back(G); sf.push_back(R);
    for (int k = 0; k < 4; k++) begin sh.push_back(Y); sf.push_back(R); end
    sh.push_back(R); sf.push_back(R);
    sh.push_back(R); sf.push_back(G);
    for (int k = 0; k < 4; k++) begin sh.push_back(R); sf.push_back(Y); end
    sh.push_back(R); sf.push_back(R);
    sh.push_back(G); sf.push_back(R);
    for (int k = 0; k < 3; k++) begin sh.push_back(Y); sf.push_back(R); end
    sh.push_back(R); sf.push_back(R);
    sh.push_back(G); sf.push_back(R);
    for (int k = 0; k < 9; k++) begin sh.push_back(Y); sf.push_back(R); end
    sh.push_back(R); sf.push_back(R);
    for (int i = 0; i < sh.size(); i++) begin
      drive(sh[i], sf[i], 1'b0);
      checks++; if (FAULT !== 1'b0) $display("FAIL legal_fault step %0d got %b want 0", i, FAULT); else passed++;
    end
    checks++; if (FAULT_CODE !== 3'd0) $display("FAIL legal_code got %0d want 0", FAULT_CODE); else passed++;
  endtask

  task automatic test_bad_trans();
    drive(G, R, 1'b0);
    checks++; if (FAULT !== 1'b0) $display("FAIL bt_pre got %b want 0", FAULT); else passed++;
    drive(R, R, 1'b0);
    checks++; if (FAULT !== 1'b1) $display("FAIL bt_fault got %b want 1", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd3) $display("FAIL bt_code got %0d want 3", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL bt_road got %b want 0", FAULT_ROAD); else passed++;
    checks++; if (FAILSAFE !== 1'b1) $display("FAIL bt_failsafe got %b want 1", FAILSAFE); else passed++;
    drive(R, 3'b011, 1'b0);
    checks++; if (FAULT_CODE !== 3'd3) $display("FAIL bt_sticky_code got %0d want 3", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL bt_sticky_road got %b want 0", FAULT_ROAD); else passed++;
    drive(R, R, 1'b0);
    drive(R, R, 1'b1);
    checks++; if (FAULT !== 1'b0) $display("FAIL bt_clr_fault got %b want 0", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd0) $display("FAIL bt_clr_code got %0d want 0", FAULT_CODE); else passed++;
    checks++; if (FAILSAFE !== 1'b0) $display("FAIL bt_clr_failsafe got %b want 0", FAILSAFE); else passed++;
  endtask

  task automatic test_flash();
    logic exp_f;
    drive(G, R, 1'b0);
    drive(R, R, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) drive(R, R, 1'b0);
`ifdef LIGHT_MONITOR_FLASH_EN
      exp_f = ((i / 8) % 2) == 0;
`else
      exp_f = 1'b0;
`endif
      checks++; if (FLASH !== exp_f) $display("FAIL flash cycle %0d got %b want %b", i, FLASH, exp_f); else passed++;
    end
    drive(R, R, 1'b1);
    checks++; if (FLASH !== 1'b0) $display("FAIL flash_clr got %b want 0", FLASH); else passed++;
    checks++; if (FAULT !== 1'b0) $display("FAIL flash_clr_fault got %b want 0", FAULT); else passed++;
  endtask

  task automatic test_yel_short();
    drive(R, G, 1'b0);
    drive(R, Y, 1'b0);
    drive(R, Y, 1'b0);
    checks++; if (FAULT !== 1'b0) $display("FAIL ys_pre got %b want 0", FAULT); else passed++;
    drive(R, R, 1'b0);
    checks++; if (FAULT !== 1'b1) $display("FAIL ys_fault got %b want 1", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd4) $display("FAIL ys_code got %0d want 4", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b1) $display("FAIL ys_road got %b want 1", FAULT_ROAD); else passed++;
    drive(R, R, 1'b1);
    checks++; if (FAULT !== 1'b0) $display("FAIL ys_clr_fault got %b want 0", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd0) $display("FAIL ys_clr_code got %0d want 0", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL ys_clr_road got %b want 0", FAULT_ROAD); else passed++;
  endtask

  task automatic test_enc_conflict();
    drive(G, R, 1'b0);
    drive(G, 3'b110, 1'b0);
    checks++; if (FAULT_CODE !== 3'd1) $display("FAIL enc_code got %0d want 1", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b1) $display("FAIL enc_road got %b want 1", FAULT_ROAD); else passed++;
    drive(R, R, 1'b0);
    drive(R, R, 1'b1);
    checks++; if (FAULT !== 1'b0) $display("FAIL enc_clr got %b want 0", FAULT); else passed++;
    drive(G, R, 1'b0);
    checks++; if (FAULT !== 1'b0) $display("FAIL cf_pre got %b want 0", FAULT); else passed++;
    drive(G, G, 1'b0);
    checks++; if (FAULT !== 1'b1) $display("FAIL cf_fault got %b want 1", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd2) $display("FAIL cf_code got %0d want 2", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL cf_road got %b want 0", FAULT_ROAD); else passed++;
  endtask

  task automatic test_clr_violation();
    drive(R, G, 1'b1);
    checks++; if (FAULT !== 1'b1) $display("FAIL clrv_fault got %b want 1", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd3) $display("FAIL clrv_code got %0d want 3", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL clrv_road got %b want 0", FAULT_ROAD); else passed++;
    drive(R, R, 1'b0);
    drive(R, R, 1'b1);
    checks++; if (FAULT !== 1'b0) $display("FAIL clrv_clr got %b want 0", FAULT); else passed++;
  endtask

  task automatic test_yel_long_reset();
    drive(G, R, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      drive(Y, R, 1'b0);
      if (k < 10) begin
        checks++; if (FAULT !== 1'b0) $display("FAIL yl_pre count %0d got %b want 0", k, FAULT); else passed++;
      end else begin
        checks++; if (FAULT !== 1'b1) $display("FAIL yl_fault got %b want 1", FAULT); else passed++;
        checks++; if (FAULT_CODE !== 3'd5) $display("FAIL yl_code got %0d want 5", FAULT_CODE); else passed++;
        checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL yl_road got %b want 0", FAULT_ROAD); else passed++;
      end
    end
    drive(Y, R, 1'b0);
    RS = 1'b0;
    #1;
    checks++; if (FAULT !== 1'b0) $display("FAIL rst_fault got %b want 0", FAULT); else passed++;
    checks++; if (FAULT_CODE !== 3'd0) $display("FAIL rst_code got %0d want 0", FAULT_CODE); else passed++;
    checks++; if (FAULT_ROAD !== 1'b0) $display("FAIL rst_road got %b want 0", FAULT_ROAD); else passed++;
    checks++; if (FAILSAFE !== 1'b0) $display("FAIL rst_failsafe got %b want 0", FAILSAFE); else passed++;
    checks++; if (FLASH !== 1'b0) $display("FAIL rst_flash got %b want 0", FLASH); else passed++;
    #2;
    RS = 1'b1;
    // Prev is red again after reset, so R->G is legal (Y->G would not be).
    drive(G, R, 1'b0);
    checks++; if (FAULT !== 1'b0) $display("FAIL rst_prev got %b want 0", FAULT); else passed++;
    repeat (3) drive(Y, R, 1'b0);
    drive(R, R, 1'b0);
    checks++; if (FAULT !== 1'b0) $display("FAIL rst_resume got %b want 0", FAULT); else passed++;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_bad_trans();
    test_flash();
    test_yel_short();
    test_enc_conflict();
    test_clr_violation();
    test_yel_long_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
